monitor_clock_stepper: RTL

MONITOR_CLOCK_STEPPER -- requirements
Module: monitor_clock_stepper

---
 rtl/monitor_clock_stepper_defs.sv | 14 +
 rtl/monitor_clock_stepper_timer.sv | 15 +
 rtl/monitor_clock_stepper.sv | 108 ++++++++++
 3 files changed

// File: rtl/monitor_clock_stepper_defs.sv
// monitor_clock_stepper_defs: register map, CTRL bit positions, FSM encoding and reset values
package monitor_clock_stepper_defs;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_COUNT = 2'd1;
  localparam logic [1:0] ADDR_HALFPER = 2'd2;
  localparam logic [1:0] ADDR_CYCLES = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_RUN = 1;
  localparam int CTRL_STOP = 2;
  localparam int CTRL_IEN = 3;
  localparam int CTRL_CLR = 4;
  localparam logic [15:0] HALFPER_RST = 16'd1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HIGH = 2'd1, ST_LOW = 2'd2} state_t;
endpackage

// File: rtl/monitor_clock_stepper_timer.sv
// monitor_clock_stepper_timer: half-period down-counter; load H, expired on the last cycle of the phase
module monitor_clock_stepper_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] h,
  output logic        expired
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? h - 16'd1 : (cnt_q != 16'd0 ? cnt_q - 16'd1 : cnt_q);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == 16'd0;
endmodule

// File: rtl/monitor_clock_stepper.sv
// monitor_clock_stepper: Avalon-MM controlled stepped clock generator with step count, free-run and done irq
module monitor_clock_stepper
  import monitor_clock_stepper_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);
  state_t state_q, state_d;
  logic [15:0] count_q, count_d, halfper_q, halfper_d, h;
  logic [31:0] cycles_q, cycles_d;
  logic done_q, done_d, ien_q, ien_d, run_q, run_d, stop_q, stop_d, out_q;
  logic wr, wr_ctrl, start, stop, busy, load, expired, rise, unused_wdata;
  assign wr = chipselect & ~write_n;
  assign wr_ctrl = wr & (address == ADDR_CTRL);
  assign start = wr_ctrl & writedata[CTRL_START];
  assign stop = wr_ctrl & writedata[CTRL_STOP];
  assign busy = state_q != ST_IDLE;
  assign h = halfper_q == 16'd0 ? 16'd1 : halfper_q;
  assign unused_wdata = ^writedata[31:16];
  monitor_clock_stepper_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .h       (h),
    .expired (expired)
  );
  always_comb begin
    state_d = state_q;
    count_d = (wr & (address == ADDR_COUNT) & ~busy) ? writedata[15:0] : count_q;
    halfper_d = (wr & (address == ADDR_HALFPER) & ~busy) ? writedata[15:0] : halfper_q;
    ien_d = wr_ctrl ? writedata[CTRL_IEN] : ien_q;
    done_d = done_q & ~(wr_ctrl & writedata[CTRL_CLR]);
    run_d = run_q;
    stop_d = stop_q | (busy & stop);
    load = 1'b0;
    // completion sets done after the W1C above, so a same-cycle set wins
    case (state_q)
      ST_IDLE:
        if (start & ~stop) begin
          if ((count_q != 16'd0) | writedata[CTRL_RUN]) begin
            state_d = ST_HIGH;
            load = 1'b1;
            done_d = 1'b0;
            run_d = writedata[CTRL_RUN];
          end else done_d = 1'b1;
        end
      ST_HIGH:
        if (expired) begin
          if (stop_d) begin
            state_d = ST_IDLE;
            done_d = 1'b1;
          end else begin
            state_d = ST_LOW;
            load = 1'b1;
          end
        end
      ST_LOW:
        if (expired) begin
          if (!run_q) count_d = count_q - 16'd1;
          if (stop_d | (~run_q & (count_q == 16'd1))) begin
            state_d = ST_IDLE;
            done_d = 1'b1;
          end else begin
            state_d = ST_HIGH;
            load = 1'b1;
          end
        end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) stop_d = 1'b0;
    rise = (state_d == ST_HIGH) & (state_q != ST_HIGH);
    cycles_d = (wr & (address == ADDR_CYCLES)) ? 32'd0 : cycles_q + {31'd0, rise};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= 16'd0;
      halfper_q <= HALFPER_RST;
      cycles_q <= 32'd0;
      done_q <= 1'b0;
      ien_q <= 1'b0;
      run_q <= 1'b0;
      stop_q <= 1'b0;
      out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      halfper_q <= halfper_d;
      cycles_q <= cycles_d;
      done_q <= done_d;
      ien_q <= ien_d;
      run_q <= run_d;
      stop_q <= stop_d;
      out_q <= state_d == ST_HIGH;
    end
  assign out_port = out_q;
  assign irq = done_q & ien_q;
  assign readdata = address == ADDR_CTRL ? {28'd0, ien_q, done_q, run_q, busy} :
                    address == ADDR_COUNT ? {16'd0, count_q} :
                    address == ADDR_HALFPER ? {16'd0, halfper_q} : cycles_q;
endmodule
